// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU for the 16-bit three-field ISA: FETCH -> EXEC -> [MEM] -> WB,
// one instruction at a time, with req/ack instruction and data memory ports.
//
// state   | meaning
// S_FETCH | imem_req held at PC until imem_ack; IR captured on ack
// S_EXEC  | ALU result, N/Z flags and next PC latched
// S_MEM   | dmem_req held until dmem_ack; load data captured on ack
// S_WB    | register write, PC update, retire pulse
module multicycle_cpu #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc,
  output logic [15:0]   ir,
  output logic          retire,
  output logic          flag_n,
  output logic          flag_z,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [6:0] OP_MOVA = 7'b0000000;
  localparam logic [6:0] OP_INC  = 7'b0000001;
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_SUB  = 7'b0000101;
  localparam logic [6:0] OP_AND  = 7'b0001000;
  localparam logic [6:0] OP_OR   = 7'b0001001;
  localparam logic [6:0] OP_XOR  = 7'b0001010;
  localparam logic [6:0] OP_NOT  = 7'b0001011;
  localparam logic [6:0] OP_MOVB = 7'b0001100;
  localparam logic [6:0] OP_LDI  = 7'b1001100;
  localparam logic [6:0] OP_ADI  = 7'b1000010;
  localparam logic [6:0] OP_LD   = 7'b0010000;
  localparam logic [6:0] OP_ST   = 7'b0100000;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_BRN  = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1110000;

  state_t state, state_nx;

  logic [DW-1:0] regs [8];
  logic [6:0]    op;
  logic [2:0]    dr, sa, sb;
  logic [DW-1:0] ra, rb, imm;
  logic [AW-1:0] ad, pc_inc, pc_tgt;

  logic [DW-1:0] alu_res;
  logic          wr_en, is_ld, is_st, known;

  logic [DW-1:0] res_q, mdr;
  logic [AW-1:0] pc_nx_q;
  logic          wr_en_q, is_ld_q;

  assign op     = ir[15:9];
  assign dr     = ir[8:6];
  assign sa     = ir[5:3];
  assign sb     = ir[2:0];
  assign ra     = regs[sa];
  assign rb     = regs[sb];
  assign imm    = DW'(sb);
  assign ad     = AW'($signed({dr, sb}));
  assign pc_inc = pc + AW'(1);

  // LD/ST/JMP pass R[SA] through the ALU, so their flags reflect the address operand.
  always_comb begin
    alu_res = ra;
    wr_en   = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    known   = 1'b1;
    pc_tgt  = pc_inc;
    case (op)
      OP_MOVA: wr_en = 1'b1;
      OP_INC:  begin alu_res = ra + DW'(1); wr_en = 1'b1; end
      OP_ADD:  begin alu_res = ra + rb;     wr_en = 1'b1; end
      OP_SUB:  begin alu_res = ra - rb;     wr_en = 1'b1; end
      OP_AND:  begin alu_res = ra & rb;     wr_en = 1'b1; end
      OP_OR:   begin alu_res = ra | rb;     wr_en = 1'b1; end
      OP_XOR:  begin alu_res = ra ^ rb;     wr_en = 1'b1; end
      OP_NOT:  begin alu_res = ~ra;         wr_en = 1'b1; end
      OP_MOVB: begin alu_res = rb;          wr_en = 1'b1; end
      OP_LDI:  begin alu_res = imm;         wr_en = 1'b1; end
      OP_ADI:  begin alu_res = ra + imm;    wr_en = 1'b1; end
      OP_LD:   begin is_ld = 1'b1;          wr_en = 1'b1; end
      OP_ST:   is_st = 1'b1;
      OP_BRZ:  if (ra == '0) pc_tgt = pc + ad;
      OP_BRN:  if (ra[DW-1]) pc_tgt = pc + ad;
      OP_JMP:  pc_tgt = AW'(ra);
      default: known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: if (imem_ack) state_nx = S_EXEC;
      S_EXEC:  state_nx = (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:   if (dmem_ack) state_nx = S_WB;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  // Requests are masked while rst is high so a pending handshake is abandoned at once.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: imem_req = 1'b1;
        S_MEM:   begin dmem_req = 1'b1; dmem_we = is_st; end
        S_WB:    retire = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      res_q   <= '0;
      mdr     <= '0;
      pc_nx_q <= '0;
      wr_en_q <= 1'b0;
      is_ld_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_EXEC: begin
          res_q   <= alu_res;
          pc_nx_q <= pc_tgt;
          wr_en_q <= wr_en;
          is_ld_q <= is_ld;
          if (known) begin
            flag_n <= alu_res[DW-1];
            flag_z <= (alu_res == '0);
          end
        end
        S_MEM: if (dmem_ack) mdr <= dmem_rdata;
        S_WB: begin
          pc <= pc_nx_q;
          if (wr_en_q) regs[dr] <= is_ld_q ? mdr : res_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = AW'(ra);
  assign dmem_wdata = rb;
  assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: an 8/8 and a 16/10 instance run the same instruction
// stream in lockstep against an ISA-level model with per-phase timing expectations.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_rdata;
  logic        imem_ack, dmem_ack;
  logic [2:0]  dbg_sel = 3'd0;

  logic        ireq0, dreq0, we0, ret0, n0, z0;
  logic [7:0]  iaddr0, daddr0, wdata0, rdata0, pc0, dbg0;
  logic [15:0] ir0;
  logic        ireq1, dreq1, we1, ret1, n1, z1;
  logic [9:0]  iaddr1, daddr1, pc1;
  logic [15:0] wdata1, rdata1, dbg1, ir1;

  always #50 clk = ~clk;

  multicycle_cpu #(.DW(8), .AW(8)) u0 (
    .clk(clk), .rst(rst), .imem_req(ireq0), .imem_addr(iaddr0), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dmem_req(dreq0), .dmem_we(we0), .dmem_addr(daddr0),
    .dmem_wdata(wdata0), .dmem_rdata(rdata0), .dmem_ack(dmem_ack), .pc(pc0), .ir(ir0),
    .retire(ret0), .flag_n(n0), .flag_z(z0), .dbg_sel(dbg_sel), .dbg_data(dbg0));

  multicycle_cpu #(.DW(16), .AW(10)) u1 (
    .clk(clk), .rst(rst), .imem_req(ireq1), .imem_addr(iaddr1), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .dmem_req(dreq1), .dmem_we(we1), .dmem_addr(daddr1),
    .dmem_wdata(wdata1), .dmem_rdata(rdata1), .dmem_ack(dmem_ack), .pc(pc1), .ir(ir1),
    .retire(ret1), .flag_n(n1), .flag_z(z1), .dbg_sel(dbg_sel), .dbg_data(dbg1));

  logic [15:0] o_iaddr [2], o_daddr [2], o_wdata [2], o_pc [2], o_ir [2], o_dbg [2];
  logic [1:0]  o_ireq, o_dreq, o_we, o_ret, o_n, o_z;
  assign o_iaddr[0] = 16'(iaddr0); assign o_iaddr[1] = 16'(iaddr1);
  assign o_daddr[0] = 16'(daddr0); assign o_daddr[1] = 16'(daddr1);
  assign o_wdata[0] = 16'(wdata0); assign o_wdata[1] = wdata1;
  assign o_pc[0]    = 16'(pc0);    assign o_pc[1]    = 16'(pc1);
  assign o_ir[0]    = ir0;         assign o_ir[1]    = ir1;
  assign o_dbg[0]   = 16'(dbg0);   assign o_dbg[1]   = dbg1;
  assign o_ireq = {ireq1, ireq0};
  assign o_dreq = {dreq1, dreq0};
  assign o_we   = {we1, we0};
  assign o_ret  = {ret1, ret0};
  assign o_n    = {n1, n0};
  assign o_z    = {z1, z0};

  int          checks = 0;
  int          errors = 0;
  int          dw_w  [2] = '{8, 16};
  logic [15:0] dmask [2] = '{16'h00FF, 16'hFFFF};
  logic [15:0] amask [2] = '{16'h00FF, 16'h03FF};

  // Architectural model state, plus the effects of the instruction in flight.
  logic [15:0] m_regs [2][8];
  logic [15:0] m_pc [2];
  bit          m_n [2], m_z [2];
  logic [15:0] dm [2][1024];
  logic [15:0] p_res [2], p_pc [2], p_addr [2], p_wdata [2];
  logic [2:0]  p_dr [2];
  bit          p_wen [2], p_ld [2], p_st [2];
  logic [15:0] snap [2][8];

  bit          chk_en = 1'b0;
  bit          exp_ireq, exp_dreq, exp_dwe, exp_ret;
  logic [15:0] exp_ir;

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_regs[d][i] = 16'h0;
      m_pc[d] = 16'h0;
      m_n[d]  = 1'b0;
      m_z[d]  = 1'b0;
    end
    exp_ir = 16'h0;
  endtask

  task automatic model_exec(input int d, input logic [15:0] ins);
    logic [6:0]  op;
    logic [2:0]  dr, sa, sb;
    logic [15:0] a, b, res, ad, npc;
    bit          known, wen;
    op = ins[15:9]; dr = ins[8:6]; sa = ins[5:3]; sb = ins[2:0];
    a = m_regs[d][sa];
    b = m_regs[d][sb];
    ad = {{10{ins[8]}}, ins[8:6], ins[2:0]};
    npc = m_pc[d] + 16'd1;
    res = a; known = 1'b1; wen = 1'b0;
    case (op)
      7'b0000000: wen = 1'b1;
      7'b0000001: begin res = a + 16'd1;      wen = 1'b1; end
      7'b0000010: begin res = a + b;          wen = 1'b1; end
      7'b0000101: begin res = a - b;          wen = 1'b1; end
      7'b0001000: begin res = a & b;          wen = 1'b1; end
      7'b0001001: begin res = a | b;          wen = 1'b1; end
      7'b0001010: begin res = a ^ b;          wen = 1'b1; end
      7'b0001011: begin res = ~a;             wen = 1'b1; end
      7'b0001100: begin res = b;              wen = 1'b1; end
      7'b1001100: begin res = {13'd0, sb};    wen = 1'b1; end
      7'b1000010: begin res = a + {13'd0, sb}; wen = 1'b1; end
      7'b0010000: wen = 1'b1;
      7'b0100000: ;
      7'b1100000: if (a == 16'h0) npc = m_pc[d] + ad;
      7'b1100001: if (a[dw_w[d]-1]) npc = m_pc[d] + ad;
      7'b1110000: npc = a;
      default:    known = 1'b0;
    endcase
    res = res & dmask[d];
    if (known) begin
      m_n[d] = res[dw_w[d]-1];
      m_z[d] = (res == 16'h0);
    end
    p_res[d] = res; p_wen[d] = wen; p_pc[d] = npc & amask[d]; p_dr[d] = dr;
    p_ld[d] = (op == 7'b0010000); p_st[d] = (op == 7'b0100000);
    p_addr[d] = a & amask[d]; p_wdata[d] = b;
  endtask

  task automatic model_wb(input int d);
    if (p_st[d]) dm[d][p_addr[d]] = p_wdata[d];
    if (p_wen[d]) m_regs[d][p_dr[d]] = p_ld[d] ? dm[d][p_addr[d]] : p_res[d];
    m_pc[d] = p_pc[d];
  endtask

  // Drive one instruction through both cores with iw fetch and dwt data wait cycles.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dwt);
    bit mem;
    mem = (ins[15:9] == 7'b0010000) || (ins[15:9] == 7'b0100000);
    for (int k = 0; k <= iw; k++) begin
      exp_ireq = 1'b1; exp_dreq = 1'b0; exp_dwe = 1'b0; exp_ret = 1'b0;
      imem_ack   = (k == iw);
      imem_rdata = (k == iw) ? ins : 16'hFFFF;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; imem_rdata = 16'hFFFF; exp_ir = ins; exp_ireq = 1'b0;
    @(posedge clk); #1;
    model_exec(0, ins);
    model_exec(1, ins);
    if (mem) begin
      for (int k = 0; k <= dwt; k++) begin
        exp_dreq = 1'b1; exp_dwe = (ins[15:9] == 7'b0100000);
        dmem_ack = (k == dwt);
        rdata0 = dm[0][p_addr[0]][7:0];
        rdata1 = dm[1][p_addr[1]];
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
    end
    exp_dreq = 1'b0; exp_dwe = 1'b0; exp_ret = 1'b1;
    @(posedge clk); #1;
    model_wb(0);
    model_wb(1);
    exp_ret = 1'b0; exp_ireq = 1'b1;
  endtask

  task automatic lit_sync();
    @(negedge clk); #20;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("imem_req", d, 16'(o_ireq[d]), 16'(exp_ireq));
        if (exp_ireq) chk("imem_addr", d, o_iaddr[d], m_pc[d]);
        chk("dmem_req", d, 16'(o_dreq[d]), 16'(exp_dreq));
        if (exp_dreq) begin
          chk("dmem_we", d, 16'(o_we[d]), 16'(exp_dwe));
          chk("dmem_addr", d, o_daddr[d], p_addr[d]);
          chk("dmem_wdata", d, o_wdata[d], p_wdata[d]);
        end
        chk("retire", d, 16'(o_ret[d]), 16'(exp_ret));
        chk("pc", d, o_pc[d], m_pc[d]);
        chk("ir", d, o_ir[d], exp_ir);
        chk("flag_n", d, 16'(o_n[d]), 16'(m_n[d]));
        chk("flag_z", d, 16'(o_z[d]), 16'(m_z[d]));
      end
      for (int i = 0; i < 8; i++) begin
        dbg_sel = 3'(i);
        #1;
        for (int d = 0; d < 2; d++) begin
          snap[d][i] = o_dbg[d];
          chk($sformatf("r%0d", i), d, o_dbg[d], m_regs[d][i]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout t=%0t actual=running expected=finished", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'hFFFF;
    rdata0 = 8'h0; rdata1 = 16'h0;
    exp_ireq = 1'b0; exp_dreq = 1'b0; exp_dwe = 1'b0; exp_ret = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 1024; a++) dm[d][a] = 16'h0;
    model_reset();

    // reset held two cycles, then fetch from 0
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ireq = 1'b1;

    // LDI R1,5; LDI R2,3; ADD R3,R1,R2; SUB R4,R2,R1 with zero-wait memory
    run_instr(16'h9845, 0, 0);
    run_instr(16'h9883, 0, 0);
    run_instr(16'h04CA, 0, 0);
    run_instr(16'h0B11, 0, 0);
    lit_sync();
    chk("lit_r3", 0, snap[0][3], 16'h0008);
    chk("lit_r4", 0, snap[0][4], 16'h00FE);
    chk("lit_r4", 1, snap[1][4], 16'hFFFE);
    chk("lit_flag_n", 0, 16'(o_n[0]), 16'h0001);

    // BRZ R0,-2 at PC=4
    run_instr(16'hC1C6, 0, 0);
    lit_sync();
    chk("lit_brz_pc", 0, o_pc[0], 16'h0002);
    chk("lit_brz_pc", 1, o_pc[1], 16'h0002);

    // ST M[R1]=R3 then LD R5=M[R1], data ack delayed two cycles
    run_instr(16'h400B, 0, 2);
    run_instr(16'h2148, 0, 2);
    lit_sync();
    chk("lit_r5", 0, snap[0][5], 16'h0008);
    chk("lit_r5", 1, snap[1][5], 16'h0008);

    // BRN R1 not taken, JMP R3
    run_instr(16'hC20B, 0, 0);
    run_instr(16'hE018, 0, 0);
    lit_sync();
    chk("lit_jmp_pc", 0, o_pc[0], 16'h0008);

    // R6 = 0 - 1, JMP R6, INC at the top address wraps to 0; one fetch wait state each
    run_instr(16'h99C1, 1, 0);
    run_instr(16'h0B87, 1, 0);
    run_instr(16'hE030, 1, 0);
    lit_sync();
    chk("lit_top_pc", 0, o_pc[0], 16'h00FF);
    chk("lit_top_pc", 1, o_pc[1], 16'h03FF);
    run_instr(16'h0290, 1, 0);
    lit_sync();
    chk("lit_wrap_pc", 0, o_pc[0], 16'h0000);
    chk("lit_wrap_pc", 1, o_pc[1], 16'h0000);

    // XOR R0 sets Z, undefined opcode keeps flags and registers, zero-wait LD
    run_instr(16'h1409, 0, 0);
    run_instr(16'hFECA, 0, 0);
    lit_sync();
    chk("lit_undef_z", 0, 16'(o_z[0]), 16'h0001);
    chk("lit_undef_pc", 0, o_pc[0], 16'h0002);
    run_instr(16'h2188, 0, 0);
    lit_sync();
    chk("lit_r6", 0, snap[0][6], 16'h0008);

    // reset during an instruction fetch wait state, ack in the reset cycle ignored
    @(posedge clk); #1;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF; exp_ireq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 16'hFFFF;
    model_reset();
    exp_ireq = 1'b1;
    run_instr(16'h9845, 0, 0);
    lit_sync();
    chk("lit_rst_pc", 0, o_pc[0], 16'h0001);
    chk("lit_rst_r1", 1, snap[1][1], 16'h0005);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
